// File: rtl/alu_serial_unit_pkg.sv
// Shared opcodes, saturation constants and FSM encoding for the serial ALU path.
package alu_serial_unit_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;
  localparam logic [3:0]  SAT_POS4  = 4'h7;
  localparam logic [3:0]  SAT_NEG4  = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SAT,
    ST_DONE
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_PADDSB);
  endfunction

endpackage

// File: rtl/alu_serial_unit_if.sv
// Request/response bus between issue logic and the serial ALU.
interface alu_serial_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  flags;
  logic        err;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, out, flags, err
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, out, flags, err
  );
endinterface

// File: rtl/alu_serial_unit_nibble_sat_adder.sv
// 4-bit adder with signed-overflow detect and a pre-saturated sum.
module nibble_sat_adder
  import alu_serial_unit_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic [3:0] sat_sum
);

  logic [4:0] full;

  // Add, then clamp toward the operand sign when the signed result wraps
  always_comb begin
    full    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    sum     = full[3:0];
    cout    = full[4];
    ovf     = (a[3] == b[3]) && (full[3] != a[3]);
    sat_sum = full[3:0];
    if (ovf) sat_sum = a[3] ? SAT_NEG4 : SAT_POS4;
  end

endmodule

// File: rtl/alu_serial_unit.sv
// Serial 16-bit ALU: one nibble per cycle through a shared 4-bit adder,
// followed by a saturation/flag stage and a held result handshake.
module alu_serial_unit
  import alu_serial_unit_pkg::*;
(
  input logic               clk,
  input logic               rst,
  alu_serial_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] res_q, res_d;
  logic        sat_any_q, sat_any_d;
  logic        ovf_neg_q, ovf_neg_d;
  logic [15:0] out_q, out_d;
  logic [2:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [3:0]  a_nib, b_nib, sum_nib, sat_nib;
  logic        cin, cout, ovf;
  logic [15:0] sat_result;

  nibble_sat_adder u_adder (
    .a       (a_nib),
    .b       (b_nib),
    .cin     (cin),
    .sum     (sum_nib),
    .cout    (cout),
    .ovf     (ovf),
    .sat_sum (sat_nib)
  );

  // Select the active nibble and carry-in for the shared adder
  always_comb begin
    a_nib = a_q[3:0];
    b_nib = b_q[3:0];
    case (cnt_q)
      2'd0: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
      2'd1: begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
      2'd2: begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
      default: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
    endcase
    if (op_q == OP_SUB) b_nib = ~b_nib;
    if (op_q == OP_PADDSB)  cin = 1'b0;
    else if (cnt_q == 2'd0) cin = (op_q == OP_SUB);
    else                    cin = carry_q;
  end

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    sat_any_d   = sat_any_q;
    ovf_neg_d   = ovf_neg_q;
    out_d       = out_q;
    flags_d     = flags_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    // Whole-word clamp applies only to ADD/SUB; PADDSB nibbles were clamped as written
    sat_result = res_q;
    if (sat_any_q && (op_q != OP_PADDSB)) sat_result = ovf_neg_q ? SAT_NEG16 : SAT_POS16;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.A;
          b_d        = bus.B;
          op_d       = bus.op;
          cnt_d      = '0;
          carry_d    = 1'b0;
          sat_any_d  = 1'b0;
          ovf_neg_d  = 1'b0;
          res_d      = '0;
          in_ready_d = 1'b0;
          if (op_is_legal(bus.op)) begin
            state_d = ST_CALC;
          end else begin
            state_d     = ST_DONE;
            out_d       = '0;
            flags_d     = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        case (cnt_q)
          2'd0: res_d[3:0]   = (op_q == OP_PADDSB) ? sat_nib : sum_nib;
          2'd1: res_d[7:4]   = (op_q == OP_PADDSB) ? sat_nib : sum_nib;
          2'd2: res_d[11:8]  = (op_q == OP_PADDSB) ? sat_nib : sum_nib;
          default: res_d[15:12] = (op_q == OP_PADDSB) ? sat_nib : sum_nib;
        endcase
        carry_d = cout;
        if (op_q == OP_PADDSB) begin
          sat_any_d = sat_any_q | ovf;
        end else if (cnt_q == 2'd3) begin
          sat_any_d = ovf;
          ovf_neg_d = a_nib[3];
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_SAT;
      end
      ST_SAT: begin
        out_d       = sat_result;
        flags_d     = {(sat_result == 16'h0000), sat_any_q, sat_result[15]};
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // FSM and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      sat_any_q   <= 1'b0;
      ovf_neg_q   <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      sat_any_q   <= sat_any_d;
      ovf_neg_q   <= ovf_neg_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_serial_unit.sv
// Directed bench for alu_serial_unit: vector table plus backpressure,
// illegal-op and mid-operation reset sequences.
module tb_alu_serial_unit;
  import alu_serial_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_serial_unit_if bus();

  alu_serial_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] exp_out;
    logic [2:0]  exp_flags;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.op       = op;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid appears (bounded)
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.a, v.b, v.op);
    wait_out(lat);
    chk({v.name, "_lat"},   lat, v.exp_lat);
    chk({v.name, "_out"},   {16'b0, bus.out}, {16'b0, v.exp_out});
    chk({v.name, "_flags"}, {29'b0, bus.flags}, {29'b0, v.exp_flags});
    chk({v.name, "_err"},   {31'b0, bus.err}, {31'b0, v.exp_err});
    release_out();
  endtask

  initial begin
    int lat;
    vec_t v;

    vecs[0]  = '{"add_basic",   16'h1234, 16'h1111, OP_ADD,    16'h2345, 3'b000, 1'b0, 5};
    vecs[1]  = '{"add_posovf",  16'h7FFF, 16'h0001, OP_ADD,    16'h7FFF, 3'b010, 1'b0, 5};
    vecs[2]  = '{"sub_negovf",  16'h8000, 16'h0001, OP_SUB,    16'h8000, 3'b011, 1'b0, 5};
    vecs[3]  = '{"sub_zero",    16'h5555, 16'h5555, OP_SUB,    16'h0000, 3'b100, 1'b0, 5};
    vecs[4]  = '{"padd_pos",    16'h7777, 16'h7777, OP_PADDSB, 16'h7777, 3'b010, 1'b0, 5};
    vecs[5]  = '{"padd_neg",    16'h8888, 16'h8888, OP_PADDSB, 16'h8888, 3'b011, 1'b0, 5};
    vecs[6]  = '{"padd_m1",     16'hCCCC, 16'h3333, OP_PADDSB, 16'hFFFF, 3'b001, 1'b0, 5};
    vecs[7]  = '{"padd_mix",    16'h4444, 16'hDDDD, OP_PADDSB, 16'h1111, 3'b000, 1'b0, 5};
    vecs[8]  = '{"illegal",     16'h1234, 16'h5678, 4'b1111,   16'h0000, 3'b000, 1'b1, 0};
    vecs[9]  = '{"add_carry",   16'h0001, 16'hFFFF, OP_ADD,    16'h0000, 3'b100, 1'b0, 5};
    vecs[10] = '{"sub_borrow",  16'h0000, 16'h0001, OP_SUB,    16'hFFFF, 3'b001, 1'b0, 5};
    vecs[11] = '{"add_negovf",  16'h8000, 16'h8000, OP_ADD,    16'h8000, 3'b011, 1'b0, 5};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out",       {16'b0, bus.out}, 32'd0);
    chk("rst_flags",     {29'b0, bus.flags}, 32'd0);
    chk("rst_err",       {31'b0, bus.err}, 32'd0);

    for (int unsigned i = 0; i < 12; i++) begin
      v = vecs[i];
      run_vec(v);
    end

    // Backpressure: result must hold while new requests are refused
    send(16'h00F0, 16'h0010, OP_ADD);
    wait_out(lat);
    chk("bp_lat", lat, 5);
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A        = 16'hFFFF;
      bus.B        = 16'hFFFF;
      bus.op       = OP_SUB;
      chk("bp_out",       {16'b0, bus.out}, 32'h0100);
      chk("bp_flags",     {29'b0, bus.flags}, 32'd0);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'b0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_out();
    v = '{"after_bp", 16'h0002, 16'h0003, OP_ADD, 16'h0005, 3'b000, 1'b0, 5};
    run_vec(v);

    // Reset while CALC is on nibble 2 discards the operation
    send(16'h1234, 16'h1111, OP_ADD);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    chk("midrst_out",       {16'b0, bus.out}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_result", {31'b0, bus.out_valid}, 32'd0);
    v = '{"post_rst", 16'h0001, 16'h0001, OP_ADD, 16'h0002, 3'b000, 1'b0, 5};
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
